cdr_shift_controller: RTL
=========================

# cdr_shift_controller

Bang-bang phase-tracking controller that drives the `sr`/`sl` shift commands of the 16-tap delay-line controller in the PRN-based CDR loop. It takes the data sample and edge sample (Alexander-type), produces early/late votes, and filters them in a signed accumulator. When the filtered error crosses a threshold it emits a one-cycle shift pulse, then holds off while the delay line settles. It mirrors the resulting tap position (mod 16) and reports lock.

## Interface
- `THRESH`, default 8: vote magnitude needed to issue a shift; range 2..64.
- `HOLDOFF`, default 16: cycles after a shift during which votes are discarded; ≥1.
- `LOCK_CNT`, default 64: consecutive valid votes without a shift needed to assert `locked`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  sample-valid qualifier for `d_smp`/`x_smp`.
- `d_smp`  in  1  data-centre sample of the current bit.
- `x_smp`  in  1  edge sample between the previous and current bit.
- `sr`  out  1  shift-right pulse; decreases delay by one tap.
- `sl`  out  1  shift-left pulse; increases delay by one tap.
- `tap`  out  4  mirrored delay-line tap index.
- `locked`  out  1  loop-lock indicator.

## Operation
- Phase detector, evaluated only when `en`=1, with `d_prev` = last accepted `d_smp`:
  - `d_prev`==`d_smp`: no transition, no vote.
  - `x_smp`==`d_smp`: LATE vote (+1).
  - `x_smp`==`d_prev`: EARLY vote (−1).
- `d_prev` updates only when `en`=1.
- Accumulator `acc`: signed, width clog2(THRESH)+2. It adds the vote only in state TRACK.
- FSM states:
  - TRACK: if `acc`+vote == +THRESH, emit `sl`, set `acc`<=0, `hold_cnt`<=HOLDOFF−1, and go to HOLD. If it equals −THRESH, do the same but emit `sr`. Otherwise `acc`<=`acc`+vote.
  - HOLD: discard votes. `acc` stays at 0. `hold_cnt` decrements each cycle, whether or not `en` is set. When `hold_cnt`==0 the next state is TRACK.
- `sr` and `sl` are never high together. Each pulse is exactly one cycle. Both are 0 in HOLD.
- `tap`: +1 on `sl` and −1 on `sr`, both mod 16 (15→0 on `sl`, 0→15 on `sr`). This matches the delay-line wrap. `tap` updates on the same edge that raises the pulse.
- Lock counter (saturates at LOCK_CNT):
  - +1 per valid vote while in TRACK with no shift issued.
  - Cleared to 0 on any shift.
  - `locked` = (counter==LOCK_CNT), registered.
  - A shift deasserts `locked` on the same edge the pulse rises.
- `en`=0 for any duration: no state change except the HOLD countdown.

## Timing
- Reset values: `sr`=0, `sl`=0, `tap`=0, `locked`=0; internally `acc`=0, `d_prev`=0, lock counter 0, state TRACK.
- Reset mid-HOLD or mid-pulse: the next cycle is at reset values, with no residual pulse.
- Latency: a vote sampled at edge n that hits the threshold drives `sr`/`sl` high during cycle n→n+1. All outputs are registered; there are no combinational paths from inputs.
- Minimum spacing between shift pulses is HOLDOFF+THRESH cycles (HOLDOFF idle cycles, then THRESH votes).
- The first sample after reset compares against `d_prev`=0.

## Structure
- Shared package `cdr_pkg`: FSM state enum (TRACK, HOLD), vote encoding (NONE, EARLY, LATE), and the tap width constant 4, which is shared with the delay-line controller.
- One sub-module `alexander_pd`:
  - Inputs: `clk`, `rst`, `en`, `d_smp`, `x_smp`.
  - Output: registered 2-bit vote.
  - Owns `d_prev`.
  - Vote latency in `cdr_shift_controller` is counted from this registered vote; the top-level edge n is the edge on which the vote is consumed.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → `sr`=`sl`=0, `tap`=0, `locked`=0 throughout.
- Steady LATE: alternate `d_smp` 0/1 with `x_smp`=`d_smp`, `en`=1, THRESH=8, HOLDOFF=16 → single `sl` pulse after the 8th vote, `tap`=1; the next `sl` comes no earlier than 16 cycles later plus 8 votes.
- Wrap: 16 consecutive EARLY-driven shifts from reset → `tap` goes 15,14,…,0; the first `sr` takes `tap` 0→15.
- Balanced votes: alternating EARLY/LATE for 200 cycles → no shift. `locked` rises after 64 votes and stays high.
- `en` gating: `en`=0 with toggling inputs → `acc` and `tap` unchanged and no pulses, but a pending HOLD still expires on time.
- Reset mid-HOLD: assert `rst` 3 cycles after an `sl` → all outputs at reset values the next cycle. A fresh 8 LATE votes are required before the next pulse.

Source files
------------

// File: rtl/cdr_pkg.sv
// cdr_pkg: shared types and constants for the CDR shift controller and delay-line controller
package cdr_pkg;
  localparam int TAP_W = 4;
  typedef enum logic {TRACK, HOLD} state_e;
  typedef enum logic [1:0] {NONE = 2'b00, EARLY = 2'b01, LATE = 2'b10} vote_e;
endpackage

// File: rtl/alexander_pd.sv
// alexander_pd: bang-bang phase detector producing a registered early/late vote
module alexander_pd
  import cdr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  d_smp,
  input  logic  x_smp,
  output vote_e vote
);
  logic  d_prev_q, d_prev_d;
  vote_e vote_q, vote_d;
  always_comb begin
    vote_d   = (!en || d_prev_q == d_smp) ? NONE : (x_smp == d_smp) ? LATE : EARLY;
    d_prev_d = en ? d_smp : d_prev_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_prev_q <= 1'b0;
      vote_q   <= NONE;
    end else begin
      d_prev_q <= d_prev_d;
      vote_q   <= vote_d;
    end
  end
  assign vote = vote_q;
endmodule

// File: rtl/cdr_shift_controller.sv
// cdr_shift_controller: filters phase votes into sr/sl shift pulses, mirrors tap, reports lock
module cdr_shift_controller
  import cdr_pkg::*;
#(
  parameter int THRESH   = 8,
  parameter int HOLDOFF  = 16,
  parameter int LOCK_CNT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_smp,
  input  logic             x_smp,
  output logic             sr,
  output logic             sl,
  output logic [TAP_W-1:0] tap,
  output logic             locked
);
  localparam int AW = $clog2(THRESH) + 2;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  vote_e                 vote;
  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d, step, sum;
  logic [HW-1:0]         hold_q, hold_d;
  logic [LW-1:0]         lock_q, lock_d;
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic                  sr_q, sr_d, sl_q, sl_d, locked_q, locked_d, shift;
  alexander_pd u_pd (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .d_smp (d_smp),
    .x_smp (x_smp),
    .vote  (vote)
  );
  always_comb begin
    step     = (vote == LATE) ? AW'(1) : (vote == EARLY) ? {AW{1'b1}} : '0;
    sum      = acc_q + step;
    sl_d     = (state_q == TRACK) && (sum == AW'(THRESH));
    sr_d     = (state_q == TRACK) && (sum == -AW'(THRESH));
    shift    = sl_d | sr_d;
    state_d  = (state_q == TRACK) ? (shift ? HOLD : TRACK) : ((hold_q == '0) ? TRACK : HOLD);
    acc_d    = (state_q == HOLD || shift) ? '0 : sum;
    hold_d   = shift ? HW'(HOLDOFF - 1) : (state_q == HOLD && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    tap_d    = tap_q + (sl_d ? TAP_W'(1) : sr_d ? {TAP_W{1'b1}} : '0);
    // votes seen while holding off are discarded and do not count toward lock
    lock_d   = shift ? '0 : (state_q == TRACK && vote != NONE && lock_q != LW'(LOCK_CNT)) ? lock_q + 1'b1 : lock_q;
    locked_d = (lock_d == LW'(LOCK_CNT));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TRACK;
      acc_q    <= '0;
      hold_q   <= '0;
      lock_q   <= '0;
      tap_q    <= '0;
      sr_q     <= 1'b0;
      sl_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      hold_q   <= hold_d;
      lock_q   <= lock_d;
      tap_q    <= tap_d;
      sr_q     <= sr_d;
      sl_q     <= sl_d;
      locked_q <= locked_d;
    end
  end
  assign sr     = sr_q;
  assign sl     = sl_q;
  assign tap    = tap_q;
  assign locked = locked_q;
endmodule
